// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the multi-channel synchroniser / debouncer slice:
//   DEFAULT_SYNC_STAGES     : default synchroniser depth
//   DEFAULT_DEBOUNCE_CYCLES : default number of consecutive differing cycles
//   clog2()                 : ceiling log2 usable in constant expressions
// -----------------------------------------------------------------------------
package debounce_pkg;

    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 3;

    // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/multi_debounced_sync_if.sv
// -----------------------------------------------------------------------------
// multi_debounced_sync_if
// Bundle between pad-side stimulus (master) and the debouncer (slave).
//   inputData   : raw asynchronous pad levels          (master -> slave)
//   outputData  : debounced stable levels              (slave -> master)
//   riseStrobe  : one-cycle 0->1 pulse per channel     (slave -> master)
//   fallStrobe  : one-cycle 1->0 pulse per channel     (slave -> master)
// With DEBOUNCE_GLITCH_CNT_EN defined, additionally:
//   clearGlitch : synchronous clear of glitch counters (master -> slave)
//   glitchCount : packed saturating counters, ch0 LSBs (slave -> master)
// -----------------------------------------------------------------------------
interface multi_debounced_sync_if #(
    parameter int CHANNELS = 2,
    parameter int GLITCH_W = 8
);

    logic [CHANNELS-1:0] inputData;
    logic [CHANNELS-1:0] outputData;
    logic [CHANNELS-1:0] riseStrobe;
    logic [CHANNELS-1:0] fallStrobe;

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic                         clearGlitch;
    logic [CHANNELS*GLITCH_W-1:0] glitchCount;

    modport master (
        output inputData,
        output clearGlitch,
        input  outputData,
        input  riseStrobe,
        input  fallStrobe,
        input  glitchCount
    );

    modport slave (
        input  inputData,
        input  clearGlitch,
        output outputData,
        output riseStrobe,
        output fallStrobe,
        output glitchCount
    );
`else
    modport master (
        output inputData,
        input  outputData,
        input  riseStrobe,
        input  fallStrobe
    );

    modport slave (
        input  inputData,
        output outputData,
        output riseStrobe,
        output fallStrobe
    );
`endif

endinterface

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One channel: SYNC_STAGES-deep synchroniser, counter-based debounce filter,
// registered rise/fall strobes and (with DEBOUNCE_GLITCH_CNT_EN) a saturating
// counter of aborted transitions.
//   fastClock   : clock, rising edge
//   reset       : asynchronous active-high reset
//   inBit       : raw asynchronous input
//   outBit      : debounced level (resets to RESET_BIT)
//   riseOut     : one-cycle pulse when outBit goes 0->1
//   fallOut     : one-cycle pulse when outBit goes 1->0
//   clearGlitch : synchronous counter clear (DEBOUNCE_GLITCH_CNT_EN only)
//   glitchCount : saturating aborted-transition count (DEBOUNCE_GLITCH_CNT_EN only)
// -----------------------------------------------------------------------------
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic RESET_BIT       = 1'b1,
    parameter int   GLITCH_W        = 8
) (
    input  logic                fastClock,
    input  logic                reset,
    input  logic                inBit,
    output logic                outBit,
    output logic                riseOut,
`ifdef DEBOUNCE_GLITCH_CNT_EN
    input  logic                clearGlitch,
    output logic [GLITCH_W-1:0] glitchCount,
`endif
    output logic                fallOut
);

    localparam int CNT_W = (clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1 : clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    if (DEBOUNCE_CYCLES < 1 || SYNC_STAGES < 2 || GLITCH_W < 1) begin : gIllegalParams
        $error("debounce_channel: DEBOUNCE_CYCLES must be >= 1, SYNC_STAGES >= 2, GLITCH_W >= 1");
    end

    logic [SYNC_STAGES-1:0] syncR;
    logic [CNT_W-1:0]       cntR;
    logic [CNT_W-1:0]       cntNextS;
    logic                   outR;
    logic                   outNextS;
    logic                   riseR;
    logic                   riseNextS;
    logic                   fallR;
    logic                   fallNextS;
    logic                   syncedS;

    assign syncedS = syncR[SYNC_STAGES-1];
    assign outBit  = outR;
    assign riseOut = riseR;
    assign fallOut = fallR;

    // Plain shift-register synchroniser, no logic between stages.
    always_ff @(posedge fastClock or posedge reset) begin
        if (reset) begin
            syncR <= {SYNC_STAGES{RESET_BIT}};
        end else begin
            syncR <= {syncR[SYNC_STAGES-2:0], inBit};
        end
    end

    // Debounce decision: a bounce back to the stable level restarts the count.
    always_comb begin
        cntNextS  = cntR;
        outNextS  = outR;
        riseNextS = 1'b0;
        fallNextS = 1'b0;
        if (syncedS == outR) begin
            cntNextS = '0;
        end else if (cntR == CNT_MAX) begin
            cntNextS  = '0;
            outNextS  = syncedS;
            riseNextS = syncedS;
            fallNextS = ~syncedS;
        end else begin
            cntNextS = cntR + CNT_ONE;
        end
    end

    // Debounce state and registered strobes; reset abandons any pending change.
    always_ff @(posedge fastClock or posedge reset) begin
        if (reset) begin
            cntR  <= '0;
            outR  <= RESET_BIT;
            riseR <= 1'b0;
            fallR <= 1'b0;
        end else begin
            cntR  <= cntNextS;
            outR  <= outNextS;
            riseR <= riseNextS;
            fallR <= fallNextS;
        end
    end

`ifdef DEBOUNCE_GLITCH_CNT_EN
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = {GLITCH_W{1'b1}};
    localparam logic [GLITCH_W-1:0] GLITCH_ONE = GLITCH_W'(1);

    logic                glitchS;
    logic [GLITCH_W-1:0] glitchR;

    // A glitch is a transition that was counting and then fell back.
    assign glitchS     = (syncedS == outR) && (cntR != '0);
    assign glitchCount = glitchR;

    // Saturating glitch counter; a coincident clear takes priority.
    always_ff @(posedge fastClock or posedge reset) begin
        if (reset) begin
            glitchR <= '0;
        end else if (clearGlitch) begin
            glitchR <= '0;
        end else if (glitchS && (glitchR != GLITCH_MAX)) begin
            glitchR <= glitchR + GLITCH_ONE;
        end else begin
            glitchR <= glitchR;
        end
    end
`endif

endmodule

// File: rtl/multi_debounced_sync.sv
// -----------------------------------------------------------------------------
// multi_debounced_sync
// Multi-channel pad synchroniser and debouncer feeding the I2C controller.
// Optional glitch counters are built only when DEBOUNCE_GLITCH_CNT_EN is defined.
//   fastClock : sole clock, rising edge
//   reset     : asynchronous active-high reset (release synchronised upstream)
//   bus       : slave side of multi_debounced_sync_if
//               (inputData, outputData, riseStrobe, fallStrobe,
//                clearGlitch/glitchCount with DEBOUNCE_GLITCH_CNT_EN)
// This level only fans the vectors out to one debounce_channel per bit.
// -----------------------------------------------------------------------------
module multi_debounced_sync
    import debounce_pkg::*;
#(
    parameter int                  CHANNELS        = 2,
    parameter int                  SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int                  DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic [CHANNELS-1:0] RESET_VALUE     = {CHANNELS{1'b1}},
    parameter int                  GLITCH_W        = 8
) (
    input  logic                   fastClock,
    input  logic                   reset,
    multi_debounced_sync_if.slave  bus
);

    if (CHANNELS < 1 || CHANNELS > 32) begin : gIllegalChannels
        $error("multi_debounced_sync: CHANNELS must be in 1..32");
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : gChannel
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_BIT       (RESET_VALUE[c]),
            .GLITCH_W        (GLITCH_W)
        ) uChannel (
            .fastClock   (fastClock),
            .reset       (reset),
            .inBit       (bus.inputData[c]),
            .outBit      (bus.outputData[c]),
            .riseOut     (bus.riseStrobe[c]),
`ifdef DEBOUNCE_GLITCH_CNT_EN
            .clearGlitch (bus.clearGlitch),
            .glitchCount (bus.glitchCount[c*GLITCH_W +: GLITCH_W]),
`endif
            .fallOut     (bus.fallStrobe[c])
        );
    end

endmodule

// File: tb/tb_multi_debounced_sync.sv
// -----------------------------------------------------------------------------
// tb_multi_debounced_sync
// Directed bench for multi_debounced_sync (2 channels, defaults, GLITCH_W = 2).
// Inputs change 1 time unit after a rising edge; outputs are sampled at that
// same point, before the inputs are updated.
// -----------------------------------------------------------------------------
module tb_multi_debounced_sync;

    localparam int GW = 2;

    logic fastClock;
    logic reset;
    int   checkCount;
    int   errorCount;

    multi_debounced_sync_if #(.CHANNELS(2), .GLITCH_W(GW)) busIf ();

    multi_debounced_sync #(
        .CHANNELS        (2),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (3),
        .RESET_VALUE     (2'b11),
        .GLITCH_W        (GW)
    ) dut (
        .fastClock (fastClock),
        .reset     (reset),
        .bus       (busIf)
    );

    initial fastClock = 1'b0;
    always #5 fastClock = ~fastClock;

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount = checkCount + 1;
        if (got !== exp) begin
            errorCount = errorCount + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge fastClock);
        #1;
    endtask

    task automatic checkOut(input string tag, input logic [1:0] expOut,
                            input logic [1:0] expRise, input logic [1:0] expFall);
        checkValue({tag, ".out"},  32'(busIf.outputData), 32'(expOut));
        checkValue({tag, ".rise"}, 32'(busIf.riseStrobe), 32'(expRise));
        checkValue({tag, ".fall"}, 32'(busIf.fallStrobe), 32'(expFall));
    endtask

    initial begin
        checkCount      = 0;
        errorCount      = 0;
        reset           = 1'b1;
        busIf.inputData = 2'b00;
`ifdef DEBOUNCE_GLITCH_CNT_EN
        busIf.clearGlitch = 1'b0;
`endif

        // 1: reset holds RESET_VALUE even though pads are low
        #12;
        checkOut("rst_hold", 2'b11, 2'b00, 2'b00);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        checkValue("rst_glitch", 32'(busIf.glitchCount), 32'd0);
`endif
        step();
        reset = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            step();
            checkOut("rel_wait", 2'b11, 2'b00, 2'b00);
        end
        step();
        checkOut("rel_fall5", 2'b00, 2'b00, 2'b11);
        step();
        checkOut("rel_fall6", 2'b00, 2'b00, 2'b00);

        // rise path on both channels, same 5-edge latency
        busIf.inputData = 2'b11;
        for (int e = 1; e <= 4; e++) begin
            step();
            checkOut("rise_wait", 2'b00, 2'b00, 2'b00);
        end
        step();
        checkOut("rise5", 2'b11, 2'b11, 2'b00);
        step();
        checkOut("rise6", 2'b11, 2'b00, 2'b00);

        // 2: ch0 steps low, ch1 stays high
        busIf.inputData = 2'b10;
        for (int e = 1; e <= 4; e++) begin
            step();
            checkOut("ch0_wait", 2'b11, 2'b00, 2'b00);
        end
        step();
        checkOut("ch0_fall", 2'b10, 2'b00, 2'b01);
        for (int e = 6; e <= 10; e++) begin
            step();
            checkOut("ch0_hold", 2'b10, 2'b00, 2'b00);
        end

        // 3: two-cycle low pulse on ch1 is rejected
        busIf.inputData = 2'b00;
        step();
        checkOut("pulse_a", 2'b10, 2'b00, 2'b00);
        step();
        checkOut("pulse_b", 2'b10, 2'b00, 2'b00);
        busIf.inputData = 2'b10;
        for (int e = 3; e <= 10; e++) begin
            step();
            checkOut("pulse_rej", 2'b10, 2'b00, 2'b00);
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        checkValue("pulse_glitch", 32'(busIf.glitchCount), 32'h4);
`endif

        // 4: bounce 0,1,0,0,0 on ch1 restarts the count
        busIf.inputData = 2'b00;
        step();
        checkOut("bnc_1", 2'b10, 2'b00, 2'b00);
        busIf.inputData = 2'b10;
        step();
        checkOut("bnc_2", 2'b10, 2'b00, 2'b00);
        busIf.inputData = 2'b00;
        for (int e = 3; e <= 6; e++) begin
            step();
            checkOut("bnc_wait", 2'b10, 2'b00, 2'b00);
        end
        step();
        checkOut("bnc_fall", 2'b00, 2'b00, 2'b10);
        step();
        checkOut("bnc_after", 2'b00, 2'b00, 2'b00);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        checkValue("bnc_glitch", 32'(busIf.glitchCount), 32'h8);
`endif

        // 5: reset two cycles into a 0->1 transition on both channels
        busIf.inputData = 2'b11;
        for (int e = 1; e <= 4; e++) begin
            step();
            checkOut("mid_wait", 2'b00, 2'b00, 2'b00);
        end
        reset = 1'b1;
        #1;
        checkOut("mid_rst", 2'b11, 2'b00, 2'b00);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        checkValue("mid_glitch", 32'(busIf.glitchCount), 32'd0);
`endif
        step();
        checkOut("mid_rst_edge", 2'b11, 2'b00, 2'b00);
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            checkOut("mid_after", 2'b11, 2'b00, 2'b00);
        end

`ifdef DEBOUNCE_GLITCH_CNT_EN
        // 6: six single-cycle glitches on ch0 saturate a 2-bit counter
        for (int g = 0; g < 6; g++) begin
            busIf.inputData = 2'b10;
            step();
            busIf.inputData = 2'b11;
            repeat (4) step();
        end
        repeat (3) step();
        checkOut("sat_out", 2'b11, 2'b00, 2'b00);
        checkValue("sat_glitch", 32'(busIf.glitchCount), 32'h3);
        busIf.clearGlitch = 1'b1;
        step();
        busIf.clearGlitch = 1'b0;
        checkValue("clr_glitch", 32'(busIf.glitchCount), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
